// File: rtl/conv_result_reader.sv
// Streams the convolution engine's result BRAM out on a valid/ready port once conv_done rises,
// through a 2-entry skid FIFO, while accumulating a wrapping checksum of the delivered words.
module conv_result_reader #(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 10,
   parameter int RES_DEPTH = 900,
   parameter int SUM_W     = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              conv_done,
   output logic              bram_en,
   output logic [ADDR_W-1:0] bram_addr,
   input  logic [DATA_W-1:0] bram_dout,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   output logic              rd_busy,
   output logic              rd_done,
   output logic [SUM_W-1:0]  checksum
);

   localparam int CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RES_DEPTH - 1);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   state_t            state;
   logic              conv_done_q;
   logic              trig;
   logic              inflight;
   logic              pop;
   logic              issue;
   logic [CNT_W-1:0]  rd_cnt;
   logic [CNT_W-1:0]  beat_cnt;
   logic [ADDR_W-1:0] addr_hold;
   logic [DATA_W-1:0] fifo_mem [2];
   logic              wr_ptr;
   logic              rd_ptr;
   logic [1:0]        fifo_count;
   logic [2:0]        occ_nxt;

   function automatic logic [SUM_W-1:0] sum_wrap(input logic [SUM_W-1:0] acc,
                                                 input logic [DATA_W-1:0] word);
      return acc + SUM_W'(word);
   endfunction

   assign trig    = conv_done && !conv_done_q && (state == IDLE || state == DONE);
   assign m_valid = (fifo_count != 2'd0);
   assign pop     = m_valid && m_ready;
   assign m_data  = m_valid ? fifo_mem[rd_ptr] : '0;
   assign m_last  = m_valid && (beat_cnt == LAST_IDX);

   // Occupancy seen by the next read: a beat leaving this cycle frees its slot, so a
   // continuously ready sink sustains one read per cycle without overflowing the FIFO.
   assign occ_nxt   = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
   assign issue     = (state == READ) && (occ_nxt < 3'd2);
   assign bram_en   = issue;
   assign bram_addr = issue ? rd_cnt[ADDR_W-1:0] : addr_hold;

   always_ff @(posedge clk) begin
      if (inflight) fifo_mem[wr_ptr] <= bram_dout;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         conv_done_q <= 1'b1;
         inflight    <= 1'b0;
         rd_cnt      <= '0;
         beat_cnt    <= '0;
         addr_hold   <= '0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         fifo_count  <= 2'd0;
         checksum    <= '0;
         rd_busy     <= 1'b0;
         rd_done     <= 1'b0;
      end else begin
         conv_done_q <= conv_done;
         inflight    <= issue;
         fifo_count  <= fifo_count + {1'b0, inflight} - {1'b0, pop};
         if (inflight) wr_ptr <= ~wr_ptr;
         if (issue) begin
            rd_cnt    <= rd_cnt + 1'b1;
            addr_hold <= rd_cnt[ADDR_W-1:0];
         end
         if (pop) begin
            rd_ptr   <= ~rd_ptr;
            checksum <= sum_wrap(checksum, m_data);
            beat_cnt <= beat_cnt + 1'b1;
         end
         case (state)
            IDLE, DONE: begin
               if (trig) begin
                  state    <= READ;
                  rd_cnt   <= '0;
                  beat_cnt <= '0;
                  checksum <= '0;
                  rd_done  <= 1'b0;
                  rd_busy  <= 1'b1;
               end
            end
            READ: begin
               if (issue && rd_cnt == LAST_IDX) state <= DRAIN;
            end
            DRAIN: begin
               if (pop && beat_cnt == LAST_IDX) begin
                  state   <= DONE;
                  rd_busy <= 1'b0;
                  rd_done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_result_reader.sv
// Bench for conv_result_reader: three instances (8-word/16-bit sum, 900-word, 1-word) driven
// by scenario tasks and compared against a word-list/checksum model of a readout.
module tb_conv_result_reader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] word_of(int mode, int a);
      case (mode)
         0:       return 16'(3 * a + 1);
         1:       return 16'hFFFF;
         default: return 16'(a);
      endcase
   endfunction

   // ---------------- instance A: RES_DEPTH=8, SUM_W=16 ----------------
   logic        a_done, a_en, a_ready, a_valid, a_last, a_busy, a_rdone;
   logic [9:0]  a_addr;
   logic [15:0] a_dout, a_data, a_sum;
   int          a_mode = 0;

   conv_result_reader #(.DATA_W(16), .ADDR_W(10), .RES_DEPTH(8), .SUM_W(16)) dut_a (
      .clk(clk), .rst(rst), .conv_done(a_done), .bram_en(a_en), .bram_addr(a_addr),
      .bram_dout(a_dout), .m_valid(a_valid), .m_ready(a_ready), .m_data(a_data),
      .m_last(a_last), .rd_busy(a_busy), .rd_done(a_rdone), .checksum(a_sum));

   logic [15:0] a_hs_data[$];
   logic        a_hs_last[$];
   int          a_hs_cyc[$];
   int          a_rd_addr[$];
   int          a_hs_n = 0;
   int          a_landed = 0;
   logic        a_infl = 1'b0;

   always @(posedge clk) begin
      if (a_en) a_dout <= word_of(a_mode, int'(a_addr));
      if (rst) begin
         a_infl   <= 1'b0;
         a_landed <= a_hs_n;
      end else begin
         a_landed <= a_landed + (a_infl ? 1 : 0);
         a_infl   <= a_en;
         if (a_en) a_rd_addr.push_back(int'(a_addr));
         if (a_valid && a_ready) begin
            a_hs_data.push_back(a_data);
            a_hs_last.push_back(a_last);
            a_hs_cyc.push_back(cyc);
            a_hs_n <= a_hs_n + 1;
         end
      end
   end

   // ---------------- instance B: RES_DEPTH=900, SUM_W=32 ----------------
   logic        b_done, b_en, b_ready, b_valid, b_last, b_busy, b_rdone;
   logic [9:0]  b_addr;
   logic [15:0] b_dout, b_data;
   logic [31:0] b_sum;

   conv_result_reader #(.DATA_W(16), .ADDR_W(10), .RES_DEPTH(900), .SUM_W(32)) dut_b (
      .clk(clk), .rst(rst), .conv_done(b_done), .bram_en(b_en), .bram_addr(b_addr),
      .bram_dout(b_dout), .m_valid(b_valid), .m_ready(b_ready), .m_data(b_data),
      .m_last(b_last), .rd_busy(b_busy), .rd_done(b_rdone), .checksum(b_sum));

   logic [15:0] b_hs_data[$];
   logic        b_hs_last[$];
   logic        b_pend = 1'b0;
   logic [15:0] b_pend_data = 16'h0;

   always @(posedge clk) begin
      if (b_en) b_dout <= word_of(2, int'(b_addr));
      if (b_valid && b_ready) begin
         b_hs_data.push_back(b_data);
         b_hs_last.push_back(b_last);
      end
      b_pend      <= b_valid && !b_ready;
      b_pend_data <= b_data;
   end

   // ---------------- instance C: RES_DEPTH=1 ----------------
   logic        c_done, c_en, c_ready, c_valid, c_last, c_busy, c_rdone;
   logic [9:0]  c_addr;
   logic [15:0] c_dout, c_data;
   logic [31:0] c_sum;

   conv_result_reader #(.DATA_W(16), .ADDR_W(10), .RES_DEPTH(1), .SUM_W(32)) dut_c (
      .clk(clk), .rst(rst), .conv_done(c_done), .bram_en(c_en), .bram_addr(c_addr),
      .bram_dout(c_dout), .m_valid(c_valid), .m_ready(c_ready), .m_data(c_data),
      .m_last(c_last), .rd_busy(c_busy), .rd_done(c_rdone), .checksum(c_sum));

   always @(posedge clk) if (c_en) c_dout <= word_of(0, int'(c_addr));

   // ---------------- shared readout check for instance A ----------------
   task automatic check_a_stream(string name, int hb, int rb, int mode);
      int n;
      logic [15:0] exp_sum;
      n = a_hs_data.size() - hb;
      checks++;
      if (n != 8) begin
         failures++;
         $display("FAIL %s_count: got %0d beats, want 8", name, n);
      end
      for (int i = 0; i < n && i < 8; i++) begin
         checks++;
         if (a_hs_data[hb+i] !== word_of(mode, i) || a_hs_last[hb+i] !== (i == 7)) begin
            failures++;
            $display("FAIL %s_beat%0d: got data=%h last=%b, want data=%h last=%b", name, i,
                     a_hs_data[hb+i], a_hs_last[hb+i], word_of(mode, i), (i == 7));
         end
      end
      checks++;
      if (a_rd_addr.size() - rb != 8) begin
         failures++;
         $display("FAIL %s_reads: got %0d reads, want 8", name, a_rd_addr.size() - rb);
      end else begin
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (a_rd_addr[rb+i] != i) begin
               failures++;
               $display("FAIL %s_addr%0d: got %0d, want %0d", name, i, a_rd_addr[rb+i], i);
            end
         end
      end
      exp_sum = 16'h0;
      for (int i = 0; i < 8; i++) exp_sum += word_of(mode, i);
      checks++;
      if (a_sum !== exp_sum || a_rdone !== 1'b1 || a_busy !== 1'b0) begin
         failures++;
         $display("FAIL %s_end: got sum=%h done=%b busy=%b, want sum=%h done=1 busy=0",
                  name, a_sum, a_rdone, a_busy, exp_sum);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      a_done = 1'b0; a_ready = 1'b0;
      b_done = 1'b0; b_ready = 1'b0;
      c_done = 1'b0; c_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({a_en, a_addr, a_valid, a_data, a_last, a_busy, a_rdone, a_sum} !== '0) begin
         failures++;
         $display("FAIL reset_a: got en=%b addr=%0d valid=%b data=%h last=%b busy=%b done=%b sum=%h, want all 0",
                  a_en, a_addr, a_valid, a_data, a_last, a_busy, a_rdone, a_sum);
      end
      checks++;
      if ({b_en, b_addr, b_valid, b_data, b_last, b_busy, b_rdone, b_sum} !== '0) begin
         failures++;
         $display("FAIL reset_b: got en=%b addr=%0d valid=%b busy=%b done=%b sum=%h, want all 0",
                  b_en, b_addr, b_valid, b_busy, b_rdone, b_sum);
      end
      checks++;
      if ({c_en, c_addr, c_valid, c_data, c_last, c_busy, c_rdone, c_sum} !== '0) begin
         failures++;
         $display("FAIL reset_c: got en=%b valid=%b busy=%b done=%b sum=%h, want all 0",
                  c_en, c_valid, c_busy, c_rdone, c_sum);
      end
      @(negedge clk); rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic();
      int hb, rb, t_done, n, h_last;
      a_mode = 0; a_ready = 1'b1;
      hb = a_hs_data.size(); rb = a_rd_addr.size();
      @(negedge clk); a_done = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (a_en !== 1'b1 || a_addr !== 10'd0) begin
         failures++;
         $display("FAIL first_read: got en=%b addr=%0d, want en=1 addr=0", a_en, a_addr);
      end
      @(negedge clk); a_done = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (a_valid !== 1'b0) begin
         failures++;
         $display("FAIL early_valid: got m_valid=%b one edge after trigger, want 0", a_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (a_valid !== 1'b1 || a_data !== word_of(0, 0)) begin
         failures++;
         $display("FAIL first_beat: got valid=%b data=%h, want valid=1 data=%h",
                  a_valid, a_data, word_of(0, 0));
      end
      for (int i = 0; i < 40 && a_rdone !== 1'b1; i++) begin
         @(posedge clk); #1;
      end
      t_done = cyc;
      check_a_stream("basic", hb, rb, 0);
      n = a_hs_data.size() - hb;
      for (int i = 1; i < n; i++) begin
         checks++;
         if (a_hs_cyc[hb+i] != a_hs_cyc[hb] + i) begin
            failures++;
            $display("FAIL basic_rate%0d: beat at cycle %0d, want %0d", i, a_hs_cyc[hb+i],
                     a_hs_cyc[hb] + i);
         end
      end
      h_last = (n > 0) ? a_hs_cyc[hb+n-1] + 1 : -1;
      checks++;
      if (t_done != h_last) begin
         failures++;
         $display("FAIL basic_done_time: rd_done seen at cycle %0d, want %0d", t_done, h_last);
      end
   endtask

   task automatic test_backpressure();
      int hb, rb, occ, max_occ, stall_left;
      bit stall_started;
      a_mode = 0; a_ready = 1'b1;
      hb = a_hs_data.size(); rb = a_rd_addr.size();
      max_occ = 0; stall_left = 0; stall_started = 0;
      @(negedge clk); a_done = 1'b1;
      @(negedge clk); a_done = 1'b0;
      for (int i = 0; i < 80 && a_rdone !== 1'b1; i++) begin
         @(negedge clk);
         if (!stall_started && (a_hs_data.size() - hb) == 3) begin
            stall_started = 1;
            stall_left = 5;
         end
         a_ready = (stall_left == 0);
         if (stall_left > 0) stall_left--;
         #1;
         occ = a_landed - a_hs_n;
         if (occ > max_occ) max_occ = occ;
         if (!a_ready && occ == 2) begin
            checks++;
            if (a_en !== 1'b0) begin
               failures++;
               $display("FAIL stall_read: got bram_en=%b with FIFO full, want 0", a_en);
            end
         end
      end
      a_ready = 1'b1;
      checks++;
      if (max_occ > 2 || !stall_started) begin
         failures++;
         $display("FAIL stall_occupancy: got max occupancy %0d stall=%0d, want <=2 with stall",
                  max_occ, stall_started);
      end
      check_a_stream("stall", hb, rb, 0);
   endtask

   task automatic test_random();
      int unstable, bad_idx, n;
      logic [31:0] exp_sum;
      int hb;
      hb = b_hs_data.size();
      unstable = 0; bad_idx = -1;
      @(negedge clk); b_done = 1'b1;
      @(negedge clk); b_done = 1'b0;
      for (int i = 0; i < 6000 && b_rdone !== 1'b1; i++) begin
         @(negedge clk);
         b_ready = ($urandom_range(0, 1) == 1);
         #1;
         if (b_pend === 1'b1 && (b_valid !== 1'b1 || b_data !== b_pend_data)) unstable++;
      end
      b_ready = 1'b0;
      n = b_hs_data.size() - hb;
      exp_sum = 32'h0;
      for (int i = 0; i < 900; i++) exp_sum += 32'(word_of(2, i));
      for (int i = 0; i < n && i < 900; i++) begin
         if (bad_idx < 0 && (b_hs_data[hb+i] !== word_of(2, i) || b_hs_last[hb+i] !== (i == 899)))
            bad_idx = i;
      end
      checks++;
      if (n != 900 || bad_idx >= 0) begin
         failures++;
         $display("FAIL random_stream: got %0d beats first bad index %0d, want 900 in order",
                  n, bad_idx);
      end
      checks++;
      if (b_sum !== exp_sum || b_rdone !== 1'b1) begin
         failures++;
         $display("FAIL random_sum: got sum=%0d done=%b, want sum=%0d done=1", b_sum, b_rdone,
                  exp_sum);
      end
      checks++;
      if (unstable != 0) begin
         failures++;
         $display("FAIL random_stable: got %0d unstable stalled cycles, want 0", unstable);
      end
   endtask

   task automatic test_reset_mid();
      int hb, rb;
      a_mode = 0; a_ready = 1'b1;
      hb = a_hs_data.size();
      @(negedge clk); a_done = 1'b1;
      for (int i = 0; i < 30 && (a_hs_data.size() - hb) < 4; i++) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if ((a_hs_data.size() - hb) != 4 ||
          {a_en, a_addr, a_valid, a_data, a_last, a_busy, a_rdone, a_sum} !== '0) begin
         failures++;
         $display("FAIL reset_mid: beats=%0d en=%b addr=%0d valid=%b data=%h busy=%b done=%b sum=%h, want 4 beats and all 0",
                  a_hs_data.size() - hb, a_en, a_addr, a_valid, a_data, a_busy, a_rdone, a_sum);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      rb = a_rd_addr.size(); hb = a_hs_data.size();
      repeat (10) @(negedge clk);
      checks++;
      if (a_busy !== 1'b0 || a_valid !== 1'b0 || a_rd_addr.size() != rb || a_hs_data.size() != hb) begin
         failures++;
         $display("FAIL reset_hold: got busy=%b valid=%b reads=%0d beats=%0d, want all 0",
                  a_busy, a_valid, a_rd_addr.size() - rb, a_hs_data.size() - hb);
      end
      a_done = 1'b0;
      @(negedge clk); a_done = 1'b1;
      for (int i = 0; i < 40 && a_rdone !== 1'b1; i++) @(negedge clk);
      check_a_stream("restart", hb, rb, 0);
      a_done = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_retrigger();
      int hb, rb;
      a_mode = 1; a_ready = 1'b1;
      hb = a_hs_data.size(); rb = a_rd_addr.size();
      @(negedge clk); a_done = 1'b1;
      @(negedge clk); a_done = 1'b0;
      for (int i = 0; i < 30 && (a_rd_addr.size() - rb) < 8; i++) @(negedge clk);
      a_ready = 1'b0;
      a_done = 1'b1;
      @(negedge clk); a_done = 1'b0;
      #1;
      checks++;
      if (a_busy !== 1'b1 || a_rdone !== 1'b0 || a_valid !== 1'b1) begin
         failures++;
         $display("FAIL drain_trigger: got busy=%b done=%b valid=%b, want busy=1 done=0 valid=1",
                  a_busy, a_rdone, a_valid);
      end
      repeat (3) @(negedge clk);
      a_ready = 1'b1;
      for (int i = 0; i < 30 && a_rdone !== 1'b1; i++) @(negedge clk);
      check_a_stream("wrap", hb, rb, 1);
      hb = a_hs_data.size(); rb = a_rd_addr.size();
      @(negedge clk); a_done = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (a_rdone !== 1'b0 || a_sum !== 16'h0 || a_busy !== 1'b1) begin
         failures++;
         $display("FAIL retrigger_clear: got done=%b sum=%h busy=%b, want done=0 sum=0 busy=1",
                  a_rdone, a_sum, a_busy);
      end
      @(negedge clk); a_done = 1'b0;
      for (int i = 0; i < 30 && a_rdone !== 1'b1; i++) @(negedge clk);
      check_a_stream("wrap2", hb, rb, 1);
   endtask

   task automatic test_single();
      int beats;
      logic [15:0] got_data;
      logic got_last;
      beats = 0; got_data = 16'h0; got_last = 1'b0;
      c_ready = 1'b1;
      @(negedge clk); c_done = 1'b1;
      @(negedge clk); c_done = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (c_valid === 1'b1) begin
            beats++;
            got_data = c_data;
            got_last = c_last;
         end
      end
      checks++;
      if (beats != 1 || got_data !== word_of(0, 0) || got_last !== 1'b1) begin
         failures++;
         $display("FAIL single_beat: got beats=%0d data=%h last=%b, want 1 beat data=%h last=1",
                  beats, got_data, got_last, word_of(0, 0));
      end
      checks++;
      if (c_sum !== 32'(word_of(0, 0)) || c_rdone !== 1'b1 || c_busy !== 1'b0) begin
         failures++;
         $display("FAIL single_end: got sum=%0d done=%b busy=%b, want sum=%0d done=1 busy=0",
                  c_sum, c_rdone, c_busy, word_of(0, 0));
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_random();
      test_reset_mid();
      test_retrigger();
      test_single();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
